ro_meas_ctrl: RTL

Measurement controller for the ring-oscillator test structure built from the team's chained `cmos_inv` cells. It enables the oscillator and lets it settle. It then counts oscillator rising edges over a programmable window of system clocks and reports the count with a done pulse. It sits between the test/CSR logic (which issues `start`) and the inverter chain (driven by `ro_en`, observed on `ro_in`).

---
 rtl/ro_meas_pkg.sv | 20 ++
 rtl/ro_meas_ctrl_sync_edge_det.sv | 33 +++
 rtl/ro_meas_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement controller.
package ro_meas_pkg;

  // Controller phases: oscillator off, warming up, counting, reporting.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } ro_state_t;

  // Default window-length and edge-counter widths.
  localparam int WIN_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  // Default warm-up length. At least 3 clocks so the synchronizer and history
  // flops hold real oscillator samples before the first counted cycle.
  localparam int SETTLE_DEF = 4;

endpackage : ro_meas_pkg

// File: rtl/ro_meas_ctrl_sync_edge_det.sv
// Brings the free-running oscillator output into the clk domain and flags each
// rising edge as a one-cycle pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its source; blocking assignments here
    // would collapse the chain into a single stage.
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Rising edge: synchronized sample is high, previous sample was low.
  assign rise = s2_q & ~s3_q;

endmodule : sync_edge_det

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enables the inverter chain, lets it
// settle, counts its rising edges over a programmable window of system clocks
// and reports the saturating count with a one-cycle done pulse.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int WIN_W  = WIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // State encodings kept as plain vectors for tools that dislike enum ports.
  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_SETTLE  = 2'(ST_SETTLE);
  localparam logic [1:0] S_MEASURE = 2'(ST_MEASURE);
  localparam logic [1:0] S_DONE    = 2'(ST_DONE);

  // Settle counter only needs to reach SETTLE-1.
  localparam int SET_W = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [SET_W-1:0] SET_LAST    = SET_W'(SETTLE - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIN_W-1:0] win_q,     win_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] acc_q,     acc_d;
  logic             sat_q,     sat_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             ovf_q,     ovf_d;

  logic             rise;

  // Oscillator edge detector; runs continuously, edges are only used in MEASURE.
  sync_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (ro_in),
    .rise (rise)
  );

  // Next-state logic for the FSM, counters, accumulator and result registers.
  always_comb begin
    // NOTE: every signal assigned in this block first takes its hold value so
    // that no path leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    win_d     = win_q;
    win_cnt_d = win_cnt_q;
    set_cnt_d = set_cnt_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d     = win_len;
          acc_d     = '0;
          sat_d     = 1'b0;
          set_cnt_d = '0;
          state_d   = S_SETTLE;
        end
      end

      S_SETTLE: begin
        set_cnt_d = set_cnt_q + SET_W'(1);
        if (set_cnt_q == SET_LAST) begin
          win_cnt_d = '0;
          if (win_q == '0) begin
            // Empty window: report the freshly cleared accumulator.
            count_d = acc_q;
            ovf_d   = sat_q;
            state_d = S_DONE;
          end else begin
            state_d = S_MEASURE;
          end
        end
      end

      S_MEASURE: begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (rise) begin
          if (acc_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            acc_d = acc_q + CNT_W'(1);
          end
        end
        if (win_cnt_q == win_q - WIN_W'(1)) begin
          // Capture the post-update value so an edge in the last window cycle counts.
          count_d = acc_d;
          ovf_d   = sat_d;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears results as well, not just control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      win_cnt_q <= '0;
      set_cnt_q <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      win_cnt_q <= win_cnt_d;
      set_cnt_q <= set_cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs decoded directly from registered state, so they are glitch-free.
  assign ro_en = (state_q == S_SETTLE) || (state_q == S_MEASURE);
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule : ro_meas_ctrl
